// File: rtl/wash_processor_ng.sv
// wash_processor_ng: instruction processor for the washing register machine.
// Fetches 32-bit words (imm[31:16], reg[15:8], opcode[7:0]) from an external
// program store at pc and sequences timed actuator ops, register ops, jumps.
// Optional call/return stack built when WASH_PROC_STACK_EN is defined.
//
// Ports:
//   clk, rst (sync, active-high), ena (low = pause)
//   instr        : instruction word at pc (combinational fetch)
//   pc           : current instruction address
//   ctrl_fill, ctrl_release, ctrl_forward, ctrl_reverse : actuator enables
//   busy         : timed operation in progress
//   halted, err  : halted (normally or on error), halted on illegal condition
module wash_processor_ng #(
    parameter int PC_W        = 8,
    parameter int DATA_W      = 16,
    parameter int REG_CNT     = 4,
    parameter int TICK_CYCLES = 1,
    parameter int STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic [31:0]     instr,
    output logic [PC_W-1:0] pc,
    output logic            ctrl_fill,
    output logic            ctrl_release,
    output logic            ctrl_forward,
    output logic            ctrl_reverse,
    output logic            busy,
    output logic            halted,
    output logic            err
);

    localparam int RIDX_W = (REG_CNT > 1) ? $clog2(REG_CNT) : 1;
    localparam int PS_W   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [7:0] OP_HALT = 8'h00;
    localparam logic [7:0] OP_WAIT = 8'h01;
    localparam logic [7:0] OP_FILL = 8'h02;
    localparam logic [7:0] OP_REL  = 8'h03;
    localparam logic [7:0] OP_FWD  = 8'h04;
    localparam logic [7:0] OP_REV  = 8'h05;
    localparam logic [7:0] OP_SET  = 8'h11;
    localparam logic [7:0] OP_DEC  = 8'h12;
    localparam logic [7:0] OP_JZ   = 8'h21;
    localparam logic [7:0] OP_JNZ  = 8'h22;
    localparam logic [7:0] OP_JMP  = 8'h23;

    typedef enum logic [1:0] {
        EXEC,
        RUN,
        HALT
    } state_t;

    state_t            state_q;
    logic [PC_W-1:0]   pc_q;
    logic [DATA_W-1:0] regs_q [REG_CNT];
    logic [15:0]       tick_q;
    logic [PS_W-1:0]   pre_q;
    // One-hot actuator select: [0] fill, [1] release, [2] forward, [3] reverse
    logic [3:0]        act_q;
    logic              busy_q;
    logic              halted_q;
    logic              err_q;

    logic [15:0]       imm;
    logic [7:0]        rfield;
    logic [7:0]        op;
    logic [RIDX_W-1:0] rsel;
    logic              reg_ok;
    logic [DATA_W-1:0] rval;
    logic              rzero;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   pc_imm;
    logic              pre_last;
    logic [3:0]        act_dec;

    assign imm    = instr[31:16];
    assign rfield = instr[15:8];
    assign op     = instr[7:0];
    assign rsel   = rfield[RIDX_W-1:0];
    // 9-bit compare so REG_CNT=256 never flags an index as illegal
    assign reg_ok = ({1'b0, rfield} < 9'(REG_CNT));
    assign rval   = regs_q[rsel];
    assign rzero  = (rval == '0);
    assign pc_inc = pc_q + PC_W'(1);
    assign pc_imm = PC_W'(imm);
    // Last clock of the current duration tick
    assign pre_last = (pre_q == PS_W'(TICK_CYCLES - 1));

    always_comb begin
        act_dec = 4'b0000;
        unique case (op)
            OP_FILL: act_dec = 4'b0001;
            OP_REL:  act_dec = 4'b0010;
            OP_FWD:  act_dec = 4'b0100;
            OP_REV:  act_dec = 4'b1000;
            default: act_dec = 4'b0000;
        endcase
    end

`ifdef WASH_PROC_STACK_EN
    localparam logic [7:0] OP_CALL = 8'h24;
    localparam logic [7:0] OP_RET  = 8'h25;
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam int SI_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_W-1:0] stk_q [STACK_DEPTH];
    logic [SP_W-1:0] sp_q;
    logic [SP_W-1:0] sp_dec;
    logic            stk_full;
    logic            stk_empty;

    assign sp_dec    = sp_q - SP_W'(1);
    assign stk_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stk_empty = (sp_q == '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EXEC;
            pc_q     <= '0;
            tick_q   <= '0;
            pre_q    <= '0;
            act_q    <= '0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < REG_CNT; i++) begin
                regs_q[i] <= '0;
            end
`ifdef WASH_PROC_STACK_EN
            sp_q <= '0;
`endif
        end else if (ena) begin
            unique case (state_q)
                EXEC: begin
                    unique case (op)
                        OP_HALT: begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end
                        OP_WAIT, OP_FILL, OP_REL, OP_FWD, OP_REV: begin
                            if (imm != 16'd0) begin
                                tick_q  <= imm;
                                pre_q   <= '0;
                                act_q   <= act_dec;
                                busy_q  <= 1'b1;
                                state_q <= RUN;
                            end else begin
                                pc_q <= pc_inc;
                            end
                        end
                        OP_SET, OP_DEC, OP_JZ, OP_JNZ: begin
                            if (!reg_ok) begin
                                state_q  <= HALT;
                                halted_q <= 1'b1;
                                err_q    <= 1'b1;
                            end else if (op == OP_SET) begin
                                regs_q[rsel] <= DATA_W'(imm);
                                pc_q         <= pc_inc;
                            end else if (op == OP_DEC) begin
                                regs_q[rsel] <= rzero ? rval
                                                      : rval - DATA_W'(1);
                                pc_q         <= pc_inc;
                            end else if (rzero == (op == OP_JZ)) begin
                                pc_q <= pc_imm;
                            end else begin
                                pc_q <= pc_inc;
                            end
                        end
                        OP_JMP: begin
                            pc_q <= pc_imm;
                        end
`ifdef WASH_PROC_STACK_EN
                        OP_CALL: begin
                            if (stk_full) begin
                                state_q  <= HALT;
                                halted_q <= 1'b1;
                                err_q    <= 1'b1;
                            end else begin
                                stk_q[sp_q[SI_W-1:0]] <= pc_inc;
                                sp_q                  <= sp_q + SP_W'(1);
                                pc_q                  <= pc_imm;
                            end
                        end
                        OP_RET: begin
                            if (stk_empty) begin
                                state_q  <= HALT;
                                halted_q <= 1'b1;
                                err_q    <= 1'b1;
                            end else begin
                                pc_q <= stk_q[sp_dec[SI_W-1:0]];
                                sp_q <= sp_dec;
                            end
                        end
`endif
                        default: begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                            err_q    <= 1'b1;
                        end
                    endcase
                end
                RUN: begin
                    if (pre_last) begin
                        pre_q  <= '0;
                        tick_q <= tick_q - 16'd1;
                        // Final tick: actuator drops on the edge pc advances
                        if (tick_q == 16'd1) begin
                            act_q   <= '0;
                            busy_q  <= 1'b0;
                            pc_q    <= pc_inc;
                            state_q <= EXEC;
                        end
                    end else begin
                        pre_q <= pre_q + PS_W'(1);
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= HALT;
                end
            endcase
        end
    end

    // Pause forces actuators off in the same cycle without losing state
    assign ctrl_fill    = act_q[0] & ena;
    assign ctrl_release = act_q[1] & ena;
    assign ctrl_forward = act_q[2] & ena;
    assign ctrl_reverse = act_q[3] & ena;
    assign pc           = pc_q;
    assign busy         = busy_q;
    assign halted       = halted_q;
    assign err          = err_q;

endmodule

// File: doc/wash_processor_ng.md
# wash_processor_ng

Parametrised next-generation instruction processor for the washing register machine. Fetches 32-bit instructions from an external program store addressed by `pc`, executes timed actuator operations (fill, release, forward, reverse), register set/decrement and conditional jumps. Adds configurable register file, data and PC widths, a duration prescaler, unconditional jump, halt and error reporting, a safety pause, and an optional call/return stack. Sits between the program ROM and the washer actuator drivers.

## Interface
- `PC_W`, 8: program counter width; program store depth 2^PC_W.
- `DATA_W`, 16: register width; must be 1..16.
- `REG_CNT`, 4: number of general registers, 1..256.
- `TICK_CYCLES`, 1: clock cycles per duration tick, ≥1.
- `STACK_DEPTH`, 4: return-stack entries, ≥1; used only with `WASH_PROC_STACK_EN`.
- `clk` in 1: clock.
- `rst` in 1: reset; one clock, synchronous, active-high.
- `ena` in 1: run enable; low = pause.
- `instr` in 32: instruction at `pc`, combinational fetch; fields are imm [31:16], reg [15:8], opcode [7:0].
- `pc` out PC_W: current instruction address.
- `ctrl_fill`, `ctrl_release`, `ctrl_forward`, `ctrl_reverse` out 1 each: actuator enables.
- `busy` out 1: timed operation in progress.
- `halted` out 1: halt reached, normally or on error.
- `err` out 1: halted on an illegal condition.

## Operation
- Opcodes: 00 halt, 01 wait, 02 fill, 03 release, 04 forward, 05 reverse, 11 set, 12 dec, 21 jz, 22 jnz, 23 jmp, 24 call, 25 ret. All others are illegal.
- States: EXEC, RUN, HALT.
- EXEC decodes `instr` in one cycle.
- Timed ops (01–05) with imm=N>0:
  - Load the tick counter with N and go to RUN.
  - In RUN, the matching `ctrl_*` is high (none for wait) and `busy`=1.
  - After N ticks: `pc`+1, return to EXEC.
  - N=0: single-cycle no-op, no actuator pulse.
- set: reg[r] = imm[DATA_W-1:0], `pc`+1.
- dec: reg[r] -= 1, saturating at 0, `pc`+1.
- jz: `pc` = imm[PC_W-1:0] if reg[r]==0, else `pc`+1. jnz is the inverse.
- jmp: `pc` = imm[PC_W-1:0] unconditionally; reg field is ignored.
- Illegal conditions, each of which enters HALT with `err`=1 and leaves `pc` unchanged:
  - reg index ≥ REG_CNT on set, dec, jz or jnz.
  - Unknown opcode.
- halt: enter HALT with `halted`=1, `err`=0, `pc` unchanged.
- HALT is left only by `rst`; `instr` is ignored while in HALT.
- `pc`+1 wraps from 2^PC_W−1 to 0.
- At most one actuator output is high in any cycle.

## Timing
- Reset values: `pc`=0, all registers=0, all `ctrl_*`=0, `busy`=0, `halted`=0, `err`=0, state EXEC, tick and prescaler counters=0, stack pointer=0.
- Each EXEC non-timed instruction takes 1 cycle; `pc` updates on the following edge.
- A timed op with N>0 takes 1 + N·TICK_CYCLES cycles of `ena`=1:
  - `ctrl_*` rises the edge after decode and stays high for exactly N·TICK_CYCLES cycles.
  - `ctrl_*` falls on the same edge that `pc` advances.
- `ena`=0 (pause):
  - State, `pc`, registers, tick and prescaler counters are frozen.
  - All `ctrl_*` are forced low combinationally in the same cycle.
  - `busy` holds its value.
  - On `ena` returning to 1, the remaining duration resumes; no cycles are lost or added.
- `rst` during RUN: all outputs return to reset values on the next edge, and the actuator drops that same edge.
- `rst` takes priority over `ena`.

## Configuration
- `WASH_PROC_STACK_EN` defined:
  - call pushes `pc`+1 (wrapped) and jumps to imm[PC_W-1:0].
  - ret pops into `pc`.
  - Push when full, or pop when empty, is an illegal condition: HALT with `err`=1.
  - Each of call and ret takes 1 cycle.
- Not defined: opcodes 24 and 25 are illegal, and no stack storage is built.

## Test plan
- Reset, then fill imm=0x20 with TICK_CYCLES=1 → `ctrl_fill` high for exactly 32 cycles; `pc` goes 0→1 on its falling edge; `busy` is high over the same window.
- forward imm=0x10 with `ena` low for 5 cycles mid-run → `ctrl_forward` low during the pause; total 16 high cycles; `pc` advances 5 cycles later than unpaused.
- Register ops:
  - set r0=0x0002, dec, dec, dec → r0 saturates at 0.
  - jz r0 target 0xCD → `pc`=0xCD.
  - set r1=0x00EA, jz r1 0xFE → `pc`+1.
  - jnz r1 0xFE → `pc`=0xFE.
- set with reg=REG_CNT (4), and separately opcode 0x7F → `halted`=1, `err`=1, `pc` unchanged, all `ctrl_*`=0; only `rst` clears the state.
- Wrap: jmp 0xFF followed by set → `pc`=0x00. Then halt → `halted`=1, `err`=0.
- With `WASH_PROC_STACK_EN` and STACK_DEPTH=4:
  - Nested call ×4 then ret ×4 → returns to each call site +1.
  - A 5th call → `err`=1.
  - ret on empty stack → `err`=1.
  - Without the macro, call → `err`=1.
